// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter sharing a one-hot-selected resource (e.g. a 2-to-4 decoder) between 4 requesters.
// Optional macro RR_DECODER_ARBITER_LOCK_EN adds a 'lock' input that suppresses the hold timeout.
module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
`ifdef RR_DECODER_ARBITER_LOCK_EN
  input  logic       lock,
`endif
  input  logic [3:0] req,
  output logic       gnt_en,
  output logic [1:0] gnt_idx,
  output logic [3:0] gnt_oh,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [1:0]       idx_q, idx_nxt;
  logic [1:0]       last_q, last_nxt;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;
  logic [3:0]       want;
  logic [2:0]       pick_all, pick_oth;
  logic             at_max;
  logic             lock_active;

  // Requester k drives req[3-k]; flip once so want[k] belongs to requester k.
  assign want   = {req[0], req[1], req[2], req[3]};
  assign at_max = (hold_cnt == CNT_W'(MAX_HOLD));

`ifdef RR_DECODER_ARBITER_LOCK_EN
  assign lock_active = lock;
`else
  assign lock_active = 1'b0;
`endif

  // Returns {found, index} of the first requester after 'last' in mod-4 order.
  function automatic logic [2:0] rr_pick(input logic [3:0] w, input logic [1:0] last);
    logic [1:0] cand;
    rr_pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      cand = last + 2'(i + 1);
      if (w[cand]) rr_pick = {1'b1, cand};
    end
  endfunction

  assign pick_all = rr_pick(want, last_q);
  assign pick_oth = rr_pick(want & ~(4'b0001 << idx_q), last_q);

  // NOTE: reset is sampled only on the clock edge, and every register uses <= so all update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx_q    <= 2'd0;
      last_q   <= 2'd3;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idx_q    <= idx_nxt;
      last_q   <= last_nxt;
      hold_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_nxt = state;
    idx_nxt   = idx_q;
    last_nxt  = last_q;
    cnt_nxt   = hold_cnt;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (pick_all[2]) begin
          state_nxt = GRANT;
          idx_nxt   = pick_all[1:0];
          last_nxt  = pick_all[1:0];
          cnt_nxt   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (!want[idx_q]) begin
          if (pick_all[2]) begin
            idx_nxt  = pick_all[1:0];
            last_nxt = pick_all[1:0];
            cnt_nxt  = CNT_W'(1);
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else if (at_max && !lock_active) begin
          // Timeout: hand over to another waiter, or restart the tenure if nobody waits.
          cnt_nxt = CNT_W'(1);
          if (pick_oth[2]) begin
            idx_nxt  = pick_oth[1:0];
            last_nxt = pick_oth[1:0];
          end
        end else if (!at_max) begin
          cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs depend only on registers, never on req.
  always_comb begin
    gnt_en  = (state == GRANT);
    busy    = gnt_en;
    gnt_idx = idx_q;
    gnt_oh  = gnt_en ? (4'b1000 >> idx_q) : 4'b0000;
  end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Self-checking bench for rr_decoder_arbiter: directed scenarios plus random traffic vs a behavioural model.
// Define RR_DECODER_ARBITER_LOCK_EN to also exercise the lock input.
module tb_rr_decoder_arbiter;
  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       gnt_en, busy;
  logic [1:0] gnt_idx;
  logic [3:0] gnt_oh;
  logic       lock_eff;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: who holds the resource, for how long, and who waits.
  bit m_en;
  int m_idx, m_last, m_tenure;
  int waited[4];

  rr_decoder_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef RR_DECODER_ARBITER_LOCK_EN
    .lock   (lock),
`endif
    .req    (req),
    .gnt_en (gnt_en),
    .gnt_idx(gnt_idx),
    .gnt_oh (gnt_oh),
    .busy   (busy)
  );

`ifdef RR_DECODER_ARBITER_LOCK_EN
  assign lock_eff = lock;
`else
  assign lock_eff = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] w, input int last);
    for (int off = 1; off <= 4; off++)
      if (w[(last + off) % 4]) return (last + off) % 4;
    return -1;
  endfunction

  task automatic model_edge(input logic [3:0] r, input logic rs, input logic lk);
    logic [3:0] w;
    int win;
    for (int k = 0; k < 4; k++) w[k] = r[3-k];
    if (rs) begin
      m_en = 0; m_idx = 0; m_last = 3; m_tenure = 0;
      for (int k = 0; k < 4; k++) waited[k] = 0;
      return;
    end
    if (!m_en || !w[m_idx]) begin
      win = pick(w, m_last);
      if (win >= 0) begin m_en = 1; m_idx = win; m_last = win; m_tenure = 1; end
      else m_en = 0;
    end else if (m_tenure >= MAX_HOLD && !lk) begin
      w[m_idx] = 1'b0;
      win = pick(w, m_last);
      if (win >= 0) begin m_idx = win; m_last = win; end
      m_tenure = 1;
    end else if (m_tenure < MAX_HOLD) begin
      m_tenure++;
    end
    for (int k = 0; k < 4; k++)
      waited[k] = (r[3-k] && !(m_en && m_idx == k)) ? waited[k] + 1 : 0;
  endtask

  // One clock: apply inputs, advance the model on the edge, compare just after it.
  task automatic step(input logic [3:0] r, input logic rs);
    logic [3:0] exp_oh;
    req = r;
    rst = rs;
    @(posedge clk);
    model_edge(r, rs, lock_eff);
    #1;
    exp_oh = m_en ? (4'b1000 >> m_idx) : 4'b0000;
    vectors++;
    if (gnt_en !== m_en) begin
      miscompares++;
      $display("FAIL gnt_en t=%0t got %b want %b", $time, gnt_en, m_en);
    end
    vectors++;
    if (gnt_idx !== 2'(m_idx)) begin
      miscompares++;
      $display("FAIL gnt_idx t=%0t got %0d want %0d", $time, gnt_idx, m_idx);
    end
    vectors++;
    if (gnt_oh !== exp_oh) begin
      miscompares++;
      $display("FAIL gnt_oh t=%0t got %b want %b", $time, gnt_oh, exp_oh);
    end
    vectors++;
    if (busy !== m_en) begin
      miscompares++;
      $display("FAIL busy t=%0t got %b want %b", $time, busy, m_en);
    end
    if (!lock_eff) begin
      for (int k = 0; k < 4; k++) begin
        if (waited[k] > 0) begin
          vectors++;
          if (waited[k] > 3*MAX_HOLD + 1) begin
            miscompares++;
            $display("FAIL starvation t=%0t requester %0d waited %0d max %0d",
                     $time, k, waited[k], 3*MAX_HOLD + 1);
          end
        end
      end
    end
  endtask

  task automatic expect_grant(input string name, input bit en, input int idx);
    vectors++;
    if (gnt_en !== en || (en && gnt_idx !== 2'(idx))) begin
      miscompares++;
      $display("FAIL %s t=%0t got en=%b idx=%0d want en=%b idx=%0d",
               name, $time, gnt_en, gnt_idx, en, idx);
    end
  endtask

  task automatic do_reset();
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    expect_grant("reset_idle", 1'b0, 0);
    vectors++;
    if (gnt_idx !== 2'd0 || gnt_oh !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outputs got idx=%0d oh=%b want idx=0 oh=0000", gnt_idx, gnt_oh);
    end
    step(4'b0010, 1'b0);
    expect_grant("first_grant_idx2", 1'b1, 2);
  endtask

  task automatic test_round_robin();
    logic [3:0] dropped;
    do_reset();
    step(4'b1111, 1'b0);
    expect_grant("rr_first", 1'b1, 0);
    for (int g = 0; g < 5; g++) begin
      step(4'b1111, 1'b0);
      expect_grant("rr_hold", 1'b1, g % 4);
      if (g < 4) begin
        dropped = 4'b1111 & ~(4'b1000 >> (g % 4));
        step(dropped, 1'b0);
        expect_grant("rr_next", 1'b1, (g + 1) % 4);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 1; c <= 24; c++) begin
      step(4'b1100, 1'b0);
      expect_grant("timeout_seq", 1'b1, ((c - 1) / MAX_HOLD) % 2);
    end
    for (int c = 0; c < 30; c++) begin
      step(4'b1000, 1'b0);
      expect_grant("sole_hold", 1'b1, 0);
    end
  endtask

  task automatic test_release_idle();
    do_reset();
    step(4'b0001, 1'b0);
    expect_grant("grant_idx3", 1'b1, 3);
    step(4'b0000, 1'b0);
    expect_grant("release_idle", 1'b0, 0);
    vectors++;
    if (gnt_idx !== 2'd3) begin
      miscompares++;
      $display("FAIL idle_keeps_idx got %0d want 3", gnt_idx);
    end
    step(4'b1001, 1'b0);
    expect_grant("wrap_to_0", 1'b1, 0);
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    for (int c = 0; c < 5; c++) step(4'b0100, 1'b0);
    expect_grant("mid_grant_idx1", 1'b1, 1);
    step(4'b1111, 1'b1);
    expect_grant("mid_grant_reset", 1'b0, 0);
    step(4'b1111, 1'b0);
    expect_grant("after_reset_idx0", 1'b1, 0);
  endtask

`ifdef RR_DECODER_ARBITER_LOCK_EN
  task automatic test_lock();
    do_reset();
    lock = 1'b1;
    for (int c = 0; c < 21; c++) begin
      step(4'b1100, 1'b0);
      expect_grant("lock_hold", 1'b1, 0);
    end
    lock = 1'b0;
    step(4'b1100, 1'b0);
    expect_grant("lock_release_switch", 1'b1, 1);
    lock = 1'b1;
    step(4'b0100, 1'b0);
    step(4'b1000, 1'b0);
    expect_grant("lock_req_drop", 1'b1, 0);
    lock = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [3:0] r;
    do_reset();
    r = 4'b0000;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(5) == 0) r[b] = ~r[b];
      step(r, ($urandom_range(199) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_timeout();
    test_release_idle();
    test_reset_mid_grant();
`ifdef RR_DECODER_ARBITER_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
